// File: rtl/itq_odd_acc.sv
// Odd-part inverse-transform accumulator: 16 coefficient x constant terms per block -> one rounded, clipped sample.
// Latency 3 edges from the 16th term; no backpressure, one term per cycle, back-to-back blocks without bubbles.
module itq_odd_acc #(
    parameter int SHIFT = 7
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_valid,
    input  logic               i_clear,
    input  logic signed [15:0] i_data,
    input  logic        [3:0]  i_idx,
    input  logic               i_sign,
    output logic               o_valid,
    output logic signed [15:0] o_data,
    output logic        [3:0]  o_cnt
);

    localparam logic signed [27:0] RND = 28'sd1 <<< (SHIFT - 1);

    logic        [3:0]  r_cnt;
    logic               r_s1_vld;
    logic               r_s1_first;
    logic               r_s1_last;
    logic signed [23:0] r_s1_prod;
    logic signed [27:0] r_acc;
    logic               r_s2_done;
    logic               r_o_vld;
    logic signed [15:0] r_o_data;

    logic signed [23:0] w_x;
    logic signed [23:0] w_mag;
    logic signed [23:0] w_prod;
    logic               w_first;
    logic               w_last;
    logic               w_s2_en;
    logic signed [27:0] w_prod_ext;
    logic signed [27:0] w_rnd;
    logic signed [27:0] w_sh;
    logic signed [15:0] w_clip;

    assign w_x = {{8{i_data[15]}}, i_data};

    // Coefficient multiply by fixed constant, shift-add decomposition per index.
    always_comb begin
        w_mag = '0;
        case (i_idx)
            4'd0:    w_mag = w_x <<< 2;
            4'd1:    w_mag = (w_x <<< 3) + (w_x <<< 2) + w_x;
            4'd2:    w_mag = (w_x <<< 4) + (w_x <<< 2) + (w_x <<< 1);
            4'd3:    w_mag = (w_x <<< 5) - w_x;
            4'd4:    w_mag = (w_x <<< 5) + (w_x <<< 2) + (w_x <<< 1);
            4'd5:    w_mag = (w_x <<< 5) + (w_x <<< 3) + (w_x <<< 2) + (w_x <<< 1);
            4'd6:    w_mag = (w_x <<< 6) - (w_x <<< 3) - (w_x <<< 1);
            4'd7:    w_mag = (w_x <<< 6) - (w_x <<< 1) - w_x;
            4'd8:    w_mag = (w_x <<< 6) + (w_x <<< 1) + w_x;
            4'd9:    w_mag = (w_x <<< 6) + (w_x <<< 3) + w_x;
            4'd10:   w_mag = (w_x <<< 6) + (w_x <<< 3) + (w_x <<< 2) + (w_x <<< 1);
            4'd11:   w_mag = (w_x <<< 6) + (w_x <<< 4) + (w_x <<< 1);
            4'd12:   w_mag = (w_x <<< 6) + (w_x <<< 4) + (w_x <<< 2) + w_x;
            4'd13:   w_mag = (w_x <<< 6) + (w_x <<< 4) + (w_x <<< 3);
            4'd14:   w_mag = (w_x <<< 6) + (w_x <<< 4) + (w_x <<< 3) + (w_x <<< 1);
            default: w_mag = '0;
        endcase
    end

    assign w_prod  = i_sign ? -w_mag : w_mag;
    // A clear restarts the block on the concurrent term, so it can be first but never last.
    assign w_first = i_clear | (r_cnt == 4'd0);
    assign w_last  = ~i_clear & (r_cnt == 4'd15);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt      <= '0;
            r_s1_vld   <= 1'b0;
            r_s1_first <= 1'b0;
            r_s1_last  <= 1'b0;
            r_s1_prod  <= '0;
        end else begin
            if (i_clear)
                r_cnt <= i_valid ? 4'd1 : 4'd0;
            else if (i_valid)
                r_cnt <= r_cnt + 4'd1;
            r_s1_vld   <= i_valid;
            r_s1_first <= w_first;
            r_s1_last  <= w_last;
            r_s1_prod  <= w_prod;
        end
    end

    // A clear drops a partial-block term in flight, but a completed block's last term still lands.
    assign w_s2_en    = r_s1_vld & (~i_clear | r_s1_last);
    assign w_prod_ext = {{4{r_s1_prod[23]}}, r_s1_prod};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc     <= '0;
            r_s2_done <= 1'b0;
        end else begin
            if (w_s2_en)
                r_acc <= r_s1_first ? w_prod_ext : (r_acc + w_prod_ext);
            r_s2_done <= r_s1_vld & r_s1_last;
        end
    end

    assign w_rnd = r_acc + RND;
    assign w_sh  = w_rnd >>> SHIFT;

    always_comb begin
        w_clip = w_sh[15:0];
        if (w_sh > 28'sd32767)
            w_clip = 16'sh7fff;
        else if (w_sh < -28'sd32768)
            w_clip = 16'sh8000;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_o_vld  <= 1'b0;
            r_o_data <= '0;
        end else begin
            r_o_vld <= r_s2_done;
            if (r_s2_done)
                r_o_data <= w_clip;
        end
    end

    assign o_valid = r_o_vld;
    assign o_data  = r_o_data;
    assign o_cnt   = r_cnt;

endmodule

// File: doc/itq_odd_acc.md
ITQ_ODD_ACC -- requirements
Module: itq_odd_acc

Interface
REQ-001 Parameter: SHIFT, default 7, right-shift applied to the accumulated sum (7 = first inverse stage, 12 = second).
REQ-002 clk  input  1  single clock; all state on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 i_valid  input  1  term present this cycle; no backpressure.
REQ-005 i_clear  input  1  synchronous discard of the partial block.
REQ-006 i_data  input  16  signed transform coefficient.
REQ-007 i_idx  input  4  constant select: 0..14 -> 4,13,22,31,38,46,54,61,67,73,78,82,85,88,90; 15 -> 0.
REQ-008 i_sign  input  1  1 = negate the product.
REQ-009 o_valid  output  1  one-cycle pulse, o_data holds a finished sample.
REQ-010 o_data  output  16  signed, rounded, clipped odd-part sum.
REQ-011 o_cnt  output  4  number of terms accepted in the current block, mod 16.

Function
REQ-012 Each block is exactly 16 valid terms; o_cnt counts 0..15, increments on i_valid, wraps 15->0 on the 16th term.
REQ-013 Stage 1: product = i_data x constant(i_idx), implemented as shift-add only (no multiplier operator), sign-extended to 24 bits, two's-complement negated when i_sign=1; registered with valid, first (o_cnt==0) and last (o_cnt==15) flags.
REQ-014 Stage 2: 28-bit signed accumulator; loads product on first term, adds product otherwise; holds when no stage-1 valid.
REQ-015 Stage 3: on the cycle after the last term enters the accumulator, o_data = clip16((acc + 2^(SHIFT-1)) >>> SHIFT), arithmetic shift (floor), clip range -32768..32767; o_valid=1 for that one cycle.
REQ-016 Latency: o_valid rises after exactly 3 rising edges counted from the edge sampling the 16th term.
REQ-017 o_data holds its last value while o_valid=0.
REQ-018 Back-to-back blocks: term 0 of block N+1 in the cycle right after term 15 of block N is accepted with no bubble; both results emitted, 16 cycles apart.
REQ-019 i_clear=1: o_cnt->0, in-flight stage-1/stage-2 terms of the partial block dropped, no o_valid for it; a result already in stage 3 is still emitted.
REQ-020 i_clear and i_valid in the same cycle: clear wins on old state; the concurrent term is accepted as term 0 of a new block (o_cnt becomes 1).
REQ-021 i_idx=15 contributes zero but counts as a term.
REQ-022 Intermediate widths never overflow: |product| <= 32768x90 fits 24 bits; 16 terms fit 28 bits.

Reset
REQ-023 rst_n low: o_valid=0, o_data=0, o_cnt=0, accumulator, pipeline valids and flags cleared, immediately and asynchronously.
REQ-024 Reset mid-block discards the partial block; the first valid after release is term 0.

Verification
REQ-025 16 terms x=100, idx=14, sign=0 -> o_valid 3 edges after 16th term, o_data=1125 (144000+64>>7).
REQ-026 16 terms x=32767, idx=14: sign=0 -> o_data=32767; sign=1 -> o_data=-32768 (clip both ends).
REQ-027 Rounding: term0 x=-17, idx=0, sign=0, remaining 15 terms idx=15 -> o_data=-1; same with x=-16 -> o_data=0.
REQ-028 8 terms then i_clear, then 16 terms x=1, idx=8 -> exactly one o_valid, o_data=8; o_cnt reads 0 after clear.
REQ-029 rst_n low after 5 terms, release, 16 terms x=100 idx=14 -> o_data=1125, no spurious o_valid during or after reset.
REQ-030 Two back-to-back blocks (x=100 idx=14, then x=-100 idx=14) -> o_valid pulses 16 cycles apart, o_data=1125 then -1125.
